updown_counter_mod: RTL and testbench

- Parametrised synchronous up/down counter; successor to the fixed 4-bit up/down counter.
- Adds count enable, parallel load, a runtime modulus limit and wrap-or-saturate selection.
- Adds a registered terminal-count pulse and a sticky overflow flag with explicit clear.
- Used as a general-purpose event/timer counter in lab designs and as a building block for dividers and sequencers.

---
 rtl/updown_counter_mod.sv | 99 +++++++++
 tb/tb_updown_counter_mod.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Parametrised synchronous up/down counter with load, runtime modulus,
// wrap/saturate boundary handling, a terminal-count pulse and a sticky overflow flag.
module updown_counter_mod #(
   parameter int WIDTH     = 8,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             m,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   input  logic             sat,
   input  logic             clr_flag,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ZERO_Q  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_Q   = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_r;
   logic             tc_r;
   logic             ovf_r;

   logic             event_s;
   logic [WIDTH-1:0] load_q_s;
   logic [WIDTH-1:0] count_q_s;

   // Boundary detection and next count value for an enabled edge
   always_comb begin
      event_s   = 1'b0;
      load_q_s  = load_val;
      count_q_s = q_r;

      if (load_val > max_val) begin
         load_q_s = max_val;
      end else begin
         load_q_s = load_val;
      end

      if (m == 1'b0) begin
         // q above a freshly lowered max_val also counts as reaching the top
         event_s = (q_r >= max_val);
         if (event_s) begin
            if (sat) begin
               count_q_s = max_val;
            end else begin
               count_q_s = ZERO_Q;
            end
         end else begin
            count_q_s = q_r + ONE_Q;
         end
      end else begin
         event_s = (q_r == ZERO_Q);
         if (event_s) begin
            if (sat) begin
               count_q_s = ZERO_Q;
            end else begin
               count_q_s = max_val;
            end
         end else if (q_r > max_val) begin
            count_q_s = max_val;
         end else begin
            count_q_s = q_r - ONE_Q;
         end
      end
   end

   // Count, load and flag registers; rst > load > en
   always_ff @(posedge clk) begin
      if (!rst) begin
         q_r   <= RESET_Q;
         tc_r  <= 1'b0;
         ovf_r <= 1'b0;
      end else if (load) begin
         q_r   <= load_q_s;
         tc_r  <= 1'b0;
         ovf_r <= 1'b0;
      end else if (en) begin
         q_r   <= count_q_s;
         tc_r  <= event_s;
         // A boundary event wins over a simultaneous clear
         ovf_r <= event_s | (ovf_r & ~clr_flag);
      end else begin
         q_r   <= q_r;
         tc_r  <= 1'b0;
         ovf_r <= ovf_r & ~clr_flag;
      end
   end

   assign q   = q_r;
   assign tc  = tc_r;
   assign ovf = ovf_r;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod (WIDTH=4): directed scenarios with constant
// expectations, then random stimulus against a rule-level reference model.
module tb_updown_counter_mod;

   localparam int W  = 4;
   localparam int RV = 0;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         m = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = 4'd0;
   logic [W-1:0] max_val = 4'd9;
   logic         sat = 1'b0;
   logic         clr_flag = 1'b0;
   logic [W-1:0] q;
   logic         tc;
   logic         ovf;

   int checks = 0;
   int failures = 0;

   // reference model state
   int mq = 0;
   int mtc = 0;
   int movf = 0;

   updown_counter_mod #(.WIDTH(W), .RESET_VAL(RV)) dut (
      .clk(clk), .rst(rst), .en(en), .m(m), .load(load), .load_val(load_val),
      .max_val(max_val), .sat(sat), .clr_flag(clr_flag), .q(q), .tc(tc), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Apply the behavioural rules to the model for the coming edge, then step one cycle.
   task automatic tick();
      int mx;
      int lv;
      bit hit;
      mx = int'(max_val);
      lv = int'(load_val);
      if (rst == 1'b0) begin
         mq = RV; mtc = 0; movf = 0;
      end else if (load) begin
         mq = (lv <= mx) ? lv : mx; mtc = 0; movf = 0;
      end else if (en) begin
         hit = (m == 1'b0) ? (mq >= mx) : (mq == 0);
         if (hit) begin
            if (m == 1'b0) mq = sat ? mx : 0;
            else           mq = sat ? 0 : mx;
            movf = 1;
         end else begin
            if (m == 1'b0)     mq = mq + 1;
            else if (mq > mx)  mq = mx;
            else               mq = mq - 1;
            if (clr_flag) movf = 0;
         end
         mtc = hit ? 1 : 0;
      end else begin
         mtc = 0;
         if (clr_flag) movf = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int v);
      load = 1'b1; en = 1'b0; load_val = W'(v);
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++;
      if (q !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset: q=%0d tc=%0b ovf=%0b, want q=0 tc=0 ovf=0", q, tc, ovf);
      end
   endtask

   task automatic test_wrap_up();
      max_val = 4'd9; sat = 1'b0; m = 1'b0; en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (q !== W'((i + 1) % 10) || tc !== (i == 9) || ovf !== (i >= 9)) begin
            failures++;
            $display("FAIL wrap_up step %0d: q=%0d tc=%0b ovf=%0b, want q=%0d tc=%0b ovf=%0b",
                     i, q, tc, ovf, (i + 1) % 10, (i == 9), (i >= 9));
         end
      end
      en = 1'b0;
   endtask

   task automatic test_sat_down();
      int exp_q [4] = '{1, 0, 0, 0};
      max_val = 4'd9;
      do_load(2);
      checks++;
      if (q !== 4'd2 || tc !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL sat_down_load: q=%0d tc=%0b ovf=%0b, want q=2 tc=0 ovf=0", q, tc, ovf);
      end
      m = 1'b1; sat = 1'b1; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (q !== W'(exp_q[i]) || tc !== (i >= 2) || ovf !== (i >= 2)) begin
            failures++;
            $display("FAIL sat_down step %0d: q=%0d tc=%0b ovf=%0b, want q=%0d tc=%0b ovf=%0b",
                     i, q, tc, ovf, exp_q[i], (i >= 2), (i >= 2));
         end
      end
      en = 1'b0; clr_flag = 1'b1;
      tick();
      clr_flag = 1'b0;
      checks++;
      if (ovf !== 1'b0 || q !== 4'd0 || tc !== 1'b0) begin
         failures++;
         $display("FAIL sat_down_clr: q=%0d tc=%0b ovf=%0b, want q=0 tc=0 ovf=0", q, tc, ovf);
      end
   endtask

   task automatic test_load_clamp();
      max_val = 4'd5;
      do_load(12);
      checks++;
      if (q !== 4'd5 || ovf !== 1'b0 || tc !== 1'b0) begin
         failures++;
         $display("FAIL load_clamp: q=%0d tc=%0b ovf=%0b, want q=5 tc=0 ovf=0", q, tc, ovf);
      end
      m = 1'b0; sat = 1'b0; en = 1'b1;
      tick();
      en = 1'b0;
      checks++;
      if (q !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
         failures++;
         $display("FAIL load_clamp_wrap: q=%0d tc=%0b ovf=%0b, want q=0 tc=1 ovf=1", q, tc, ovf);
      end
   endtask

   task automatic test_max_lowered();
      max_val = 4'd9;
      do_load(7);
      max_val = 4'd3; sat = 1'b1; m = 1'b0; en = 1'b1;
      tick();
      en = 1'b0;
      checks++;
      if (q !== 4'd3 || tc !== 1'b1) begin
         failures++;
         $display("FAIL max_lowered_up: q=%0d tc=%0b, want q=3 tc=1", q, tc);
      end
      max_val = 4'd9;
      do_load(7);
      max_val = 4'd3; sat = 1'b1; m = 1'b1; en = 1'b1;
      tick();
      checks++;
      if (q !== 4'd3 || tc !== 1'b0) begin
         failures++;
         $display("FAIL max_lowered_dn1: q=%0d tc=%0b, want q=3 tc=0", q, tc);
      end
      tick();
      en = 1'b0;
      checks++;
      if (q !== 4'd2 || tc !== 1'b0) begin
         failures++;
         $display("FAIL max_lowered_dn2: q=%0d tc=%0b, want q=2 tc=0", q, tc);
      end
   endtask

   task automatic test_reset_priority();
      max_val = 4'd9;
      do_load(9);
      m = 1'b0; sat = 1'b1; en = 1'b1;
      tick();
      m = 1'b1; sat = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (q !== 4'd6 || ovf !== 1'b1) begin
         failures++;
         $display("FAIL rst_prio_setup: q=%0d ovf=%0b, want q=6 ovf=1", q, ovf);
      end
      rst = 1'b0; load = 1'b1; load_val = 4'd3;
      tick();
      rst = 1'b1; load = 1'b0; en = 1'b0;
      checks++;
      if (q !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL rst_prio: q=%0d tc=%0b ovf=%0b, want q=0 tc=0 ovf=0", q, tc, ovf);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q !== 4'd0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL rst_hold step %0d: q=%0d tc=%0b, want q=0 tc=0", i, q, tc);
         end
      end
   endtask

   task automatic test_event_clr();
      max_val = 4'd9;
      do_load(9);
      m = 1'b0; sat = 1'b0; en = 1'b1; clr_flag = 1'b1;
      tick();
      en = 1'b0; clr_flag = 1'b0;
      checks++;
      if (q !== 4'd0 || ovf !== 1'b1 || tc !== 1'b1) begin
         failures++;
         $display("FAIL event_clr: q=%0d tc=%0b ovf=%0b, want q=0 tc=1 ovf=1", q, tc, ovf);
      end
   endtask

   task automatic test_max_zero();
      max_val = 4'd0;
      do_load(0);
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m = i[0]; sat = i[1];
         tick();
         checks++;
         if (q !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL max_zero step %0d: q=%0d tc=%0b ovf=%0b, want q=0 tc=1 ovf=1", i, q, tc, ovf);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 59) != 0);
         load     = ($urandom_range(0, 9) == 0);
         load_val = W'($urandom_range(0, 15));
         en       = ($urandom_range(0, 3) != 0);
         m        = (i % 40 < 20) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
         sat      = $urandom_range(0, 1);
         clr_flag = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 14) == 0) max_val = W'($urandom_range(0, 15));
         tick();
         checks++;
         if (q !== W'(mq) || tc !== mtc[0] || ovf !== movf[0]) begin
            failures++;
            $display("FAIL random step %0d: q=%0d tc=%0b ovf=%0b, want q=%0d tc=%0d ovf=%0d",
                     i, q, tc, ovf, mq, mtc, movf);
         end
      end
      rst = 1'b1; load = 1'b0; en = 1'b0; clr_flag = 1'b0;
   endtask

   initial begin
      #2;
      test_reset();
      test_wrap_up();
      test_sat_down();
      test_load_clamp();
      test_max_lowered();
      test_reset_priority();
      test_event_clr();
      test_max_zero();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
